// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch address with stall, sticky halt,
// branch/jump redirect, call/return and a circular return-address stack.
module pc_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       STEP      = 1,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall,
    input  logic                               halt,
    input  logic                               redirect,
    input  logic [ADDR_W-1:0]                  target,
    input  logic                               call,
    input  logic                               ret,
    output logic [ADDR_W-1:0]                  pc_out,
    output logic [ADDR_W-1:0]                  pc_plus,
    output logic [ADDR_W-1:0]                  ras_top,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
    output logic                               ras_overflow,
    output logic                               ras_underflow,
    output logic                               halted
);

    localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              halted_q, halted_d;
    logic              push_s;

    assign pc_plus = pc_q + ADDR_W'(STEP);

    // Next-state selection in priority order: halt > stall > ret > redirect > increment.
    always_comb begin
        pc_d     = pc_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        halted_d = halted_q;
        push_s   = 1'b0;
        if (halted_q || halt) begin
            halted_d = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (cnt_q != '0) begin
                pc_d  = ras_q[ptr_q];
                ptr_d = ptr_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                pc_d  = pc_plus;
                unf_d = 1'b1;
            end
        end else if (redirect) begin
            pc_d = target;
            if (call) begin
                push_s = 1'b1;
                ptr_d  = ptr_q + PTR_W'(1);
                // A full stack keeps its count; the push silently replaces the oldest slot.
                if (cnt_q == FULL_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                push_s = 1'b0;
            end
        end else begin
            pc_d = pc_plus;
        end
    end

    // PC, stack pointer, count and sticky status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            ptr_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            halted_q <= halted_d;
        end
    end

    // Return-address storage; the pushed value is the pre-update pc_plus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (push_s) begin
            ras_q[ptr_d] <= pc_plus;
        end
    end

    assign pc_out        = pc_q;
    assign ras_top       = (cnt_q == '0) ? '0 : ras_q[ptr_q];
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit (ADDR_W=32, RAS_DEPTH=4).
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, halt = 1'b0, redirect = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] target = 32'h0;
    logic [31:0] pc_out, pc_plus, ras_top;
    logic [2:0]  ras_count;
    logic        ras_overflow, ras_underflow, halted;

    int tests = 0;
    int fails = 0;

    pc_unit #(.ADDR_W(32), .RESET_PC(32'h0), .STEP(1), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt), .redirect(redirect),
        .target(target), .call(call), .ret(ret), .pc_out(pc_out), .pc_plus(pc_plus),
        .ras_top(ras_top), .ras_count(ras_count), .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, halt, redirect, call, ret;
        logic [31:0] target;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic [31:0] e_top;
        logic        e_ovf, e_unf, e_halt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic h, input logic rd,
                       input logic c, input logic rt, input logic [31:0] tg,
                       input logic [31:0] pc, input logic [2:0] cnt, input logic [31:0] top,
                       input logic ovf, input logic unf, input logic hl);
        vec_t v;
        v.rst = r; v.stall = s; v.halt = h; v.redirect = rd; v.call = c; v.ret = rt;
        v.target = tg; v.e_pc = pc; v.e_cnt = cnt; v.e_top = top;
        v.e_ovf = ovf; v.e_unf = unf; v.e_halt = hl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [31:0] pc, input logic [2:0] cnt,
                           input logic [31:0] top, input logic ovf, input logic unf, input logic hl);
        logic [31:0] nxt;
        nxt = pc + 32'd1;
        chk("pc_out", idx, pc_out, pc);
        chk("pc_plus", idx, pc_plus, nxt);
        chk("ras_count", idx, {29'd0, ras_count}, {29'd0, cnt});
        chk("ras_top", idx, ras_top, top);
        chk("ras_overflow", idx, {31'd0, ras_overflow}, {31'd0, ovf});
        chk("ras_underflow", idx, {31'd0, ras_underflow}, {31'd0, unf});
        chk("halted", idx, {31'd0, halted}, {31'd0, hl});
    endtask

    initial begin
        // Reset then plain increment.
        add(1,0,0,0,0,0, 32'h0,   32'h0, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,0,0,0, 32'h0,   32'h1, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,0,0,0, 32'h0,   32'h2, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,0,0,0, 32'h0,   32'h3, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,0,0,0, 32'h0,   32'h4, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,0,0,0, 32'h0,   32'h5, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,0,0,0, 32'h0,   32'h6, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,0,0,0, 32'h0,   32'h7, 3'd0, 32'h0, 0,0,0);
        // Stall drops a concurrent redirect; releasing it lets the redirect act.
        add(0,1,0,1,0,0, 32'h40,  32'h7, 3'd0, 32'h0, 0,0,0);
        add(0,1,0,1,0,0, 32'h40,  32'h7, 3'd0, 32'h0, 0,0,0);
        add(0,1,0,1,0,0, 32'h40,  32'h7, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,1,0,0, 32'h40,  32'h40, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,0,0,0, 32'h0,   32'h41, 3'd0, 32'h0, 0,0,0);
        // Nested call/return.
        add(0,0,0,1,0,0, 32'hA,   32'hA, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,1,1,0, 32'h100, 32'h100, 3'd1, 32'hB, 0,0,0);
        add(0,0,0,1,1,0, 32'h200, 32'h200, 3'd2, 32'h101, 0,0,0);
        add(0,0,0,0,0,1, 32'h0,   32'h101, 3'd1, 32'hB, 0,0,0);
        add(0,0,0,0,0,1, 32'h0,   32'hB, 3'd0, 32'h0, 0,0,0);
        // Pop beats a simultaneous redirect (and its call).
        add(0,0,0,1,1,0, 32'h300, 32'h300, 3'd1, 32'hC, 0,0,0);
        add(0,0,0,1,1,1, 32'h500, 32'hC, 3'd0, 32'h0, 0,0,0);
        // Call alone is a no-op; stall drops a call+redirect.
        add(0,0,0,0,1,0, 32'h777, 32'hD, 3'd0, 32'h0, 0,0,0);
        add(0,1,0,1,1,0, 32'h999, 32'hD, 3'd0, 32'h0, 0,0,0);
        // Address wrap-around, and a call at all-ones pushes 0.
        add(0,0,0,1,0,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,0,0,0, 32'h0,   32'h0, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,1,0,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 32'h0, 0,0,0);
        add(0,0,0,1,1,0, 32'h20,  32'h20, 3'd1, 32'h0, 0,0,0);
        add(0,0,0,0,0,1, 32'h0,   32'h0, 3'd0, 32'h0, 0,0,0);
        // Five calls overflow the 4-deep stack; four pops then an underflow.
        add(0,0,0,1,1,0, 32'h10,  32'h10, 3'd1, 32'h1, 0,0,0);
        add(0,0,0,1,1,0, 32'h20,  32'h20, 3'd2, 32'h11, 0,0,0);
        add(0,0,0,1,1,0, 32'h30,  32'h30, 3'd3, 32'h21, 0,0,0);
        add(0,0,0,1,1,0, 32'h40,  32'h40, 3'd4, 32'h31, 0,0,0);
        add(0,0,0,1,1,0, 32'h50,  32'h50, 3'd4, 32'h41, 1,0,0);
        add(0,0,0,0,0,1, 32'h0,   32'h41, 3'd3, 32'h31, 1,0,0);
        add(0,0,0,0,0,1, 32'h0,   32'h31, 3'd2, 32'h21, 1,0,0);
        add(0,0,0,0,0,1, 32'h0,   32'h21, 3'd1, 32'h11, 1,0,0);
        add(0,0,0,0,0,1, 32'h0,   32'h11, 3'd0, 32'h0, 1,0,0);
        add(0,0,0,0,0,1, 32'h0,   32'h12, 3'd0, 32'h0, 1,1,0);
        add(0,0,0,0,0,0, 32'h0,   32'h13, 3'd0, 32'h0, 1,1,0);
        add(0,0,0,1,1,0, 32'h20,  32'h20, 3'd1, 32'h14, 1,1,0);
        // Halt with a concurrent redirect: PC and stack freeze.
        add(0,0,1,1,0,0, 32'h99,  32'h20, 3'd1, 32'h14, 1,1,1);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; stall = vecs[i].stall; halt = vecs[i].halt;
            redirect = vecs[i].redirect; call = vecs[i].call; ret = vecs[i].ret;
            target = vecs[i].target;
            @(posedge clk);
            #1;
            chk_all(i, vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_top,
                    vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_halt);
        end

        // While halted, every strobe combination is ignored.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            halt = 1'b0; redirect = 1'b1;
            call = k[0]; ret = k[1]; stall = k[2];
            target = 32'h100 + k;
            @(posedge clk);
            #1;
            chk_all(100 + k, 32'h20, 3'd1, 32'h14, 1'b1, 1'b1, 1'b1);
        end

        // Asynchronous reset mid-cycle clears everything without waiting for an edge.
        @(negedge clk);
        stall = 1'b0; redirect = 1'b0; call = 1'b0; ret = 1'b0; target = 32'h0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_all(200, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all(201, 32'h1, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all(202, 32'h2, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
